// File: rtl/countdown_timer_pkg.sv
// Shared types and sizing helpers for the loadable countdown timer.
// Prescaler sizing is used only when COUNTDOWN_TIMER_PRESCALE_EN is defined.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int PRESCALE_DIV_DEFAULT = 4;

    // A divide-by-1 prescaler still needs a 1-bit counter to stay legal.
    function automatic int presc_width(input int div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

    localparam int PRESC_W = presc_width(PRESCALE_DIV_DEFAULT);

endpackage

// File: rtl/tick_prescaler.sv
// Counts enable cycles and emits a tick on every DIV-th one.
// The tick is combinational so that it lines up with the enable that completes the group.
module tick_prescaler
    import countdown_timer_pkg::*;
#(
    parameter int DIV = PRESCALE_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = presc_width(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot / auto-reload, pause and resume.
// Define COUNTDOWN_TIMER_PRESCALE_EN to decrement only on every PRESCALE_DIV-th enab.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH        = 5,
    parameter int PRESCALE_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             load,
    input  logic             start,
    input  logic             stop,
    input  logic             enab,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] cnt_out,
    output logic             busy,
    output logic             tc,
    output logic             done,
    output state_t           state_dbg
);

    state_t           state;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] restart_val;
    logic             run_en;
    logic             start_ok;
    logic             step;

    // Every higher-priority control masks both the decrement and the start.
    assign run_en      = (state == RUN) && enab && !load && !stop;
    assign start_ok    = start && !load && !stop && (state != RUN);
    assign restart_val = (state == DONE) ? reload : cnt_out;
    assign state_dbg   = state;

`ifdef COUNTDOWN_TIMER_PRESCALE_EN
    logic terminal_reload;

    assign terminal_reload = step && (cnt_out <= WIDTH'(1)) && auto_reload;

    tick_prescaler #(
        .DIV (PRESCALE_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (load || start_ok || terminal_reload),
        .en   (run_en),
        .tick (step)
    );
`else
    // An invalid divider (< 1) leaves the timer unable to count.
    assign step = run_en && (PRESCALE_DIV >= 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt_out <= '0;
            reload  <= '0;
            busy    <= 1'b0;
            tc      <= 1'b0;
            done    <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                cnt_out <= cnt_in;
                reload  <= cnt_in;
                state   <= IDLE;
                busy    <= 1'b0;
                done    <= 1'b0;
            end else if (stop) begin
                if (state == RUN) begin
                    state <= HOLD;
                end
            end else if (start_ok) begin
                if (state == HOLD) begin
                    state <= RUN;
                end else if (restart_val == '0) begin
                    // Starting from zero finishes at once rather than wrapping.
                    cnt_out <= '0;
                    state   <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    tc      <= 1'b1;
                end else begin
                    cnt_out <= restart_val;
                    state   <= RUN;
                    busy    <= 1'b1;
                    done    <= 1'b0;
                end
            end else if (step) begin
                if (cnt_out > WIDTH'(1)) begin
                    cnt_out <= cnt_out - 1'b1;
                end else begin
                    tc <= 1'b1;
                    if (auto_reload) begin
                        cnt_out <= reload;
                    end else begin
                        cnt_out <= '0;
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized bench for countdown_timer with a reference model and an expected-value queue.
// Honors COUNTDOWN_TIMER_PRESCALE_EN the same way the design does.
module tb_countdown_timer;
    import countdown_timer_pkg::*;

    localparam int WIDTH = 5;
    localparam int DIV   = 4;
    localparam int EW    = WIDTH + 5;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] cnt_in;
    logic             load;
    logic             start;
    logic             stop;
    logic             enab;
    logic             auto_reload;
    logic [WIDTH-1:0] cnt_out;
    logic             busy;
    logic             tc;
    logic             done;
    state_t           state_dbg;

    countdown_timer #(
        .WIDTH        (WIDTH),
        .PRESCALE_DIV (DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cnt_in      (cnt_in),
        .load        (load),
        .start       (start),
        .stop        (stop),
        .enab        (enab),
        .auto_reload (auto_reload),
        .cnt_out     (cnt_out),
        .busy        (busy),
        .tc          (tc),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion before 2000000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    // Expected vector layout: {cnt_out, busy, tc, done, state}
    logic [EW-1:0] exp_q[$];
    int     vectors     = 0;
    int     miscompares = 0;

    int     m_cnt;
    int     m_rel;
    state_t m_st;
    bit     m_tc;
    int     m_pre;

    task automatic model_step();
        bit fire;
        m_tc = 1'b0;
        if (rst) begin
            m_cnt = 0; m_rel = 0; m_st = IDLE; m_pre = 0;
        end else if (load) begin
            m_cnt = int'(cnt_in); m_rel = int'(cnt_in); m_st = IDLE; m_pre = 0;
        end else if (stop) begin
            if (m_st == RUN) m_st = HOLD;
        end else if (start && m_st != RUN) begin
            m_pre = 0;
            if (m_st == HOLD) begin
                m_st = RUN;
            end else begin
                if (m_st == DONE) m_cnt = m_rel;
                if (m_cnt == 0) begin
                    m_st = DONE; m_tc = 1'b1;
                end else begin
                    m_st = RUN;
                end
            end
        end else if (m_st == RUN && enab) begin
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
            m_pre = m_pre + 1;
            fire  = (m_pre == DIV);
            if (fire) m_pre = 0;
`else
            fire = 1'b1;
`endif
            if (fire) begin
                if (m_cnt > 1) begin
                    m_cnt = m_cnt - 1;
                end else begin
                    m_tc = 1'b1;
                    if (auto_reload) begin
                        m_cnt = m_rel;
                    end else begin
                        m_cnt = 0; m_st = DONE;
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit r, input bit l, input int v, input bit s,
                         input bit p, input bit e, input bit a);
        logic busy_e;
        @(negedge clk);
        rst = r; load = l; cnt_in = WIDTH'(v); start = s; stop = p; enab = e; auto_reload = a;
        @(posedge clk);
        model_step();
        busy_e = (m_st == RUN) || (m_st == HOLD);
        exp_q.push_back({WIDTH'(m_cnt), busy_e, m_tc, (m_st == DONE), m_st});
    endtask

    task automatic run_cycles(input int n, input bit e, input bit a);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, e, a);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = {cnt_out, busy, tc, done, state_dbg};
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL outputs vec %0d @%0t: got cnt=%0d busy=%0b tc=%0b done=%0b st=%0d, expected cnt=%0d busy=%0b tc=%0b done=%0b st=%0d",
                             vectors, $time, got[EW-1:5], got[4], got[3], got[2], got[1:0],
                             exp[EW-1:5], exp[4], exp[3], exp[2], exp[1:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; load = 1'b0; cnt_in = '0; start = 1'b0; stop = 1'b0;
        enab = 1'b0; auto_reload = 1'b0;
        m_cnt = 0; m_rel = 0; m_st = IDLE; m_tc = 1'b0; m_pre = 0;

        // reset, then quiet idle with enab high
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        run_cycles(4, 1, 0);

        // one-shot from 5
        drive(0, 1, 5, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0, 1, 0);
        run_cycles(30, 1, 0);

        // auto-reload from 3 with enab gaps
        drive(0, 1, 3, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 40; i++) drive(0, 0, 0, 0, 0, (i % 2) == 0, 1);

        // pause, simultaneous start+stop, resume
        drive(0, 1, 10, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0, 1, 0);
        run_cycles(4 * DIV, 1, 0);
        drive(0, 0, 0, 0, 1, 1, 0);
        run_cycles(3, 1, 0);
        drive(0, 0, 0, 1, 1, 1, 0);
        drive(0, 0, 0, 1, 1, 1, 0);
        drive(0, 0, 0, 1, 0, 1, 0);
        run_cycles(6 * DIV, 1, 0);

        // zero load: immediate DONE with a tc, then restart from zero reload
        drive(0, 1, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0, 1, 0);
        run_cycles(3, 1, 0);
        drive(0, 0, 0, 1, 0, 1, 0);
        run_cycles(2, 1, 0);

        // abort a running count with a fresh load
        drive(0, 1, 7, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0, 1, 0);
        run_cycles(3 * DIV, 1, 0);
        drive(0, 1, 7, 0, 0, 1, 0);
        run_cycles(3, 1, 0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 19) == 0,
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5)),
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 11) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1);
        end

        // drain
        run_cycles(2, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
